// File: rtl/alu_pipe_if.sv
// Opcode encodings and the issue/CDB bundle shared by the ALU and its neighbours.
// Ports: master = RS + CDB side (drives op, operands, flush, yumi_in);
//        slave = ALU side (drives ready and the out_* packet).
package alu_pipe_pkg;
  // Bit 2 set selects the subtract datapath (SUB, SLT, SLTU and unknowns 0111/11xx).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_type_e;
endpackage

interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int ROB_W = 4
);
  logic             valid_in;
  logic             ready;
  logic [3:0]       ALUop;
  logic [2:0]       branch_type;
  logic             load;
  logic [ROB_W-1:0] rs_rob_entry;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             flush;
  logic             yumi_in;
  logic             valid_out;
  logic [WIDTH-1:0] out_result;
  logic [ROB_W-1:0] out_rob;
  logic             out_branch;
  logic             out_load_step1;

  modport master (
    output valid_in, ALUop, branch_type, load, rs_rob_entry, rs1, rs2, flush, yumi_in,
    input  ready, valid_out, out_result, out_rob, out_branch, out_load_step1
  );

  modport slave (
    input  valid_in, ALUop, branch_type, load, rs_rob_entry, rs1, rs2, flush, yumi_in,
    output ready, valid_out, out_result, out_rob, out_branch, out_load_step1
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined integer ALU: computes at issue, carries the packet through STAGES registers to the CDB.
// Latency STAGES cycles, 1 op/cycle; valid/yumi at the output, bubbles collapse, ready drops only when all stages hold ops.
// Ports: clk, reset (async active-low), bus (alu_pipe_if.slave: issue op/operands, flush, yumi_in in; ready, out_* out).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ROB_W  = 4,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [ROB_W-1:0] rob;
    logic             branch;
    logic             load;
  } pkt_t;

  // ---------------- issue-side compute ----------------
  logic             sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             carry, flag_n, flag_z, flag_v, lt;
  logic [SH_W-1:0]  shamt;
  pkt_t             in_pkt;

  assign sub      = bus.ALUop[2];
  assign b_opnd   = sub ? ~bus.rs2 : bus.rs2;
  // Subtract as rs1 + ~rs2 + 1 in WIDTH+1 bits so carry=1 means "no borrow".
  assign sum_full = {1'b0, bus.rs1} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, sub};
  assign sum      = sum_full[WIDTH-1:0];
  assign carry    = sum_full[WIDTH];
  assign flag_n   = sum[WIDTH-1];
  assign flag_z   = (sum == '0);
  // Carry-in to msb xor carry-out: operands agree in sign but the sum does not.
  assign flag_v   = (bus.rs1[WIDTH-1] == b_opnd[WIDTH-1]) && (flag_n != bus.rs1[WIDTH-1]);
  assign lt       = flag_n ^ flag_v;
  assign shamt    = bus.rs2[SH_W-1:0];

  always_comb begin
    in_pkt      = '0;
    in_pkt.rob  = bus.rs_rob_entry;
    in_pkt.load = bus.load;
    case (bus.ALUop)
      ALU_SLT:  in_pkt.result = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLTU: in_pkt.result = {{(WIDTH-1){1'b0}}, ~carry};
      ALU_XOR:  in_pkt.result = bus.rs1 ^ bus.rs2;
      ALU_OR:   in_pkt.result = bus.rs1 | bus.rs2;
      ALU_AND:  in_pkt.result = bus.rs1 & bus.rs2;
      ALU_SLL:  in_pkt.result = bus.rs1 << shamt;
      ALU_SRL:  in_pkt.result = bus.rs1 >> shamt;
      ALU_SRA:  in_pkt.result = WIDTH'($signed(bus.rs1) >>> shamt);
      default:  in_pkt.result = sum;
    endcase
    case (bus.branch_type)
      BR_EQ:   in_pkt.branch = flag_z;
      BR_NE:   in_pkt.branch = ~flag_z;
      BR_LT:   in_pkt.branch = lt;
      BR_GE:   in_pkt.branch = ~lt;
      BR_LTU:  in_pkt.branch = ~carry;
      BR_GEU:  in_pkt.branch = carry;
      default: in_pkt.branch = 1'b0;
    endcase
  end

  // ---------------- pipeline ----------------
  pkt_t              stg_q [STAGES];
  pkt_t              stg_d [STAGES];
  logic [STAGES-1:0] v_q, v_d, adv;
  logic              hs;

  // Stage i can advance unless it and every stage after it are full and the CDB is not taking.
  // Stages below i are forced to 1 by the mask so only the tail [STAGES-1:i] is tested.
  always_comb begin
    adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      adv[i] = bus.yumi_in | ~(&(v_q | ((STAGES'(1) << i) - STAGES'(1))));
    end
  end

  assign bus.ready = adv[0] & ~bus.flush & reset;
  assign hs        = bus.valid_in & bus.ready;

  always_comb begin
    v_d   = v_q;
    stg_d = stg_q;
    if (bus.flush) begin
      // Data registers keep their contents; only occupancy is squashed.
      v_d = '0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) stg_d[i] = stg_q[i-1];
        end
      end
      if (adv[0]) begin
        v_d[0] = hs;
        if (hs) stg_d[0] = in_pkt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) stg_q[i] <= stg_d[i];
    end
  end

  assign bus.valid_out      = v_q[STAGES-1];
  assign bus.out_result     = stg_q[STAGES-1].result;
  assign bus.out_rob        = stg_q[STAGES-1].rob;
  assign bus.out_branch     = stg_q[STAGES-1].branch;
  assign bus.out_load_step1 = stg_q[STAGES-1].load;
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ROB_W  = 4;
  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(WIDTH), .ROB_W(ROB_W)) bus ();
  alu_pipe #(.WIDTH(WIDTH), .ROB_W(ROB_W), .STAGES(STAGES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rob;
    logic        br;
    logic        ld;
    int          t;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   mode  = 0;  // 0: yumi held low, 1: yumi whenever valid_out, 2: random yumi

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      default:  return op[2] ? a - b : a + b;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
    case (br)
      BR_EQ:   return a == b;
      BR_NE:   return a != b;
      BR_LT:   return $signed(a) < $signed(b);
      BR_GE:   return $signed(a) >= $signed(b);
      BR_LTU:  return a < b;
      BR_GEU:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Compare process: checks every cycle, then updates the model for the coming edge.
  always @(negedge clk) begin : mon
    logic exp_vo, exp_rdy;
    exp_t e;
    if (!reset) begin
      q.delete();
      chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_result", bus.out_result, 32'd0);
      chk("rst_rob", 32'(bus.out_rob), 32'd0);
    end else begin
      // The oldest op is never blocked ahead of it, so it shows exactly STAGES cycles after acceptance.
      exp_vo  = (q.size() != 0) && (cyc - q[0].t >= STAGES);
      exp_rdy = !bus.flush && (q.size() < STAGES || bus.yumi_in);
      chk("valid_out", 32'(bus.valid_out), 32'(exp_vo));
      chk("ready", 32'(bus.ready), 32'(exp_rdy));
      if (exp_vo && bus.valid_out) begin
        chk("out_result", bus.out_result, q[0].res);
        chk("out_rob", 32'(bus.out_rob), 32'(q[0].rob));
        chk("out_branch", 32'(bus.out_branch), 32'(q[0].br));
        chk("out_load", 32'(bus.out_load_step1), 32'(q[0].ld));
      end
      if (bus.flush) begin
        q.delete();
      end else begin
        if (bus.valid_out && bus.yumi_in && q.size() != 0) void'(q.pop_front());
        if (bus.valid_in && bus.ready) begin
          e.res = ref_res(bus.ALUop, bus.rs1, bus.rs2);
          e.br  = ref_br(bus.branch_type, bus.rs1, bus.rs2);
          e.rob = bus.rs_rob_entry;
          e.ld  = bus.load;
          e.t   = cyc;
          q.push_back(e);
        end
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    bus.yumi_in = bus.valid_out && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1));
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] br, input logic ld,
                       input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
    bus.valid_in     = v;
    bus.ALUop        = op;
    bus.branch_type  = br;
    bus.load         = ld;
    bus.rs_rob_entry = tag;
    bus.rs1          = a;
    bus.rs2          = b;
  endtask

  // Issue one op into an empty pipe and pin the result with literal expectations.
  task automatic send1(input string name, input logic [3:0] op, input logic [2:0] br, input logic [3:0] tag,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] x_res, input logic x_br);
    @(posedge clk); #2;
    drive(1'b1, op, br, 1'b0, tag, a, b);
    @(negedge clk);
    chk({name, "_acc"}, 32'(bus.ready), 32'd1);
    @(posedge clk); #2;
    bus.valid_in = 1'b0;
    repeat (STAGES - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_vo"}, 32'(bus.valid_out), 32'd1);
    chk({name, "_res"}, bus.out_result, x_res);
    chk({name, "_br"}, 32'(bus.out_branch), 32'(x_br));
    chk({name, "_rob"}, 32'(bus.out_rob), 32'(tag));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, ALU_ADD, BR_NONE, 1'b0, 4'd0, 32'd0, 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    // Directed literal cases.
    mode = 1;
    send1("add",  ALU_ADD, BR_NONE, 4'd3, 32'd5, 32'd7, 32'd12, 1'b0);
    send1("blt",  ALU_SUB, BR_LT,   4'd4, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);
    send1("bltu", ALU_SUB, BR_LTU,  4'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
    send1("beq",  ALU_SUB, BR_EQ,   4'd6, 32'd9, 32'd9, 32'd0, 1'b1);
    send1("sra",  ALU_SRA, BR_NONE, 4'd7, 32'h8000_0000, 32'd36, 32'hF800_0000, 1'b0);
    send1("srl",  ALU_SRL, BR_NONE, 4'd8, 32'h8000_0000, 32'd36, 32'h0800_0000, 1'b0);
    send1("slt",  ALU_SLT, BR_NONE, 4'd9, 32'h8000_0000, 32'd1, 32'd1, 1'b0);

    // Backpressure: STAGES+1 back-to-back ops with yumi low.
    mode = 0;
    for (int k = 0; k <= STAGES; k++) begin
      @(posedge clk); #2;
      drive(1'b1, ALU_ADD, BR_NONE, k[0], 4'(k + 1), 32'(k * 100), 32'(k));
      @(negedge clk);
      chk("bp_ready", 32'(bus.ready), (k < STAGES) ? 32'd1 : 32'd0);
    end
    repeat (3) begin
      @(negedge clk);
      chk("bp_full", 32'(bus.ready), 32'd0);
    end
    mode = 2;
    begin : wait_acc
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.ready) disable wait_acc;
      end
      chk("bp_accept_timeout", 32'(bus.ready), 32'd1);
    end
    @(posedge clk); #2;
    bus.valid_in = 1'b0;
    drain("bp_drain");

    // Flush with two ops in flight plus a new op in the flush cycle.
    mode = 0;
    @(posedge clk); #2; drive(1'b1, ALU_XOR, BR_NONE, 1'b0, 4'd1, 32'hA5A5_0000, 32'h0F0F_0F0F);
    @(posedge clk); #2; drive(1'b1, ALU_OR,  BR_NONE, 1'b1, 4'd2, 32'h1234_0000, 32'h0000_5678);
    @(posedge clk); #2; drive(1'b1, ALU_AND, BR_NONE, 1'b0, 4'd3, 32'hFFFF_0000, 32'h00FF_FF00);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #2;
    bus.flush = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("fl_vo", 32'(bus.valid_out), 32'd0);
    chk("fl_ready_after", 32'(bus.ready), 32'd1);
    chk("fl_model_empty", 32'(q.size()), 32'd0);

    // Randomized traffic with random yumi and occasional flush.
    mode = 2;
    repeat (3000) begin
      logic [2:0] br;
      logic [3:0] op;
      @(posedge clk); #2;
      br = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : BR_NONE;
      op = (br != BR_NONE) ? ALU_SUB : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 9) < 7, op, br, 1'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, $urandom);
      bus.flush = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #2;
    bus.valid_in = 1'b0;
    bus.flush = 1'b0;
    drain("rnd_drain");

    // Async reset while stalled, then normal latency afterwards.
    mode = 0;
    @(posedge clk); #2; drive(1'b1, ALU_ADD, BR_NONE, 1'b1, 4'd11, 32'd1000, 32'd1);
    @(posedge clk); #2; drive(1'b1, ALU_SUB, BR_NONE, 1'b0, 4'd12, 32'd50, 32'd8);
    @(posedge clk); #2; bus.valid_in = 1'b0;
    repeat (STAGES + 2) @(negedge clk);
    chk("rs_stalled", 32'(bus.valid_out), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rs_vo", 32'(bus.valid_out), 32'd0);
    chk("rs_res", bus.out_result, 32'd0);
    chk("rs_rob", 32'(bus.out_rob), 32'd0);
    chk("rs_br", 32'(bus.out_branch), 32'd0);
    chk("rs_ld", 32'(bus.out_load_step1), 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    mode = 1;
    send1("post_rst", ALU_ADD, BR_NONE, 4'd13, 32'd20, 32'd22, 32'd42, 1'b0);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
